// File: rtl/spi_cmd_master_if.sv
// Control handshake and SPI pin bundle for spi_cmd_master.
// The master modport is the controller's view; the slave modport is the requester/flash side.
interface spi_cmd_master_if #(
  parameter int CMD_W        = 8,
  parameter int MAX_RX_BYTES = 4
);
  localparam int LEN_W = $clog2(MAX_RX_BYTES + 1);

  logic                      start;
  logic [CMD_W-1:0]          cmd;
  logic [LEN_W-1:0]          rx_len;
  logic                      busy;
  logic                      done;
  logic [8*MAX_RX_BYTES-1:0] rx_data;
  logic                      cs_n;
  logic                      sclk;
  logic                      mosi;
  logic                      miso;

  modport master (
    input  start, cmd, rx_len, miso,
    output busy, done, rx_data, cs_n, sclk, mosi
  );

  modport slave (
    output start, cmd, rx_len, miso,
    input  busy, done, rx_data, cs_n, sclk, mosi
  );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI command master: asserts CS, shifts a CMD_W-bit instruction out MSB-first, reads 0..MAX_RX_BYTES bytes.
// Every bit is CLK_DIV cycles with sclk low then CLK_DIV cycles high; CPOL only sets the idle level.
module spi_cmd_master #(
  parameter int   CLK_DIV      = 4,
  parameter int   CMD_W        = 8,
  parameter int   MAX_RX_BYTES = 4,
  parameter logic CPOL         = 1'b0
) (
  input logic              clk,
  input logic              reset,
  spi_cmd_master_if.master bus
);
  localparam int LEN_W    = $clog2(MAX_RX_BYTES + 1);
  localparam int RX_W     = 8 * MAX_RX_BYTES;
  localparam int MAX_BITS = (CMD_W > RX_W) ? CMD_W : RX_W;
  localparam int BIT_W    = $clog2(MAX_BITS + 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_CS,
    SEND_CMD,
    GET_DATA,
    DEASSERT_CS
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic [BIT_W-1:0] bit_cnt;
  logic [CMD_W-1:0] cmd_sh;
  logic [RX_W-1:0]  rx_sh;
  logic [RX_W-1:0]  rx_data;
  logic [LEN_W-1:0] len_q;
  logic             busy;
  logic             done;
  logic             cs_n;
  logic             sclk;
  logic             mosi;
  logic             half_end;

  assign half_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rx_data = rx_data;
  assign bus.cs_n    = cs_n;
  assign bus.sclk    = sclk;
  assign bus.mosi    = mosi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      cmd_sh  <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      len_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= CPOL;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          phase   <= 1'b0;
          // The done cycle refuses start so a held request still sees one idle cycle.
          if (bus.start && !done) begin
            state  <= ASSERT_CS;
            cs_n   <= 1'b0;
            busy   <= 1'b1;
            mosi   <= bus.cmd[CMD_W-1];
            cmd_sh <= {bus.cmd[CMD_W-2:0], 1'b0};
            len_q  <= (bus.rx_len > LEN_W'(MAX_RX_BYTES)) ? LEN_W'(MAX_RX_BYTES) : bus.rx_len;
            rx_sh  <= '0;
          end
        end

        ASSERT_CS: begin
          if (half_end) begin
            state   <= SEND_CMD;
            div_cnt <= '0;
            phase   <= 1'b0;
            sclk    <= 1'b0;
            bit_cnt <= BIT_W'(CMD_W - 1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SEND_CMD, GET_DATA: begin
          if (!half_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (!phase) begin
              // This edge raises sclk; miso has been stable for the whole low half.
              sclk <= 1'b1;
              if (state == GET_DATA) rx_sh <= {rx_sh[RX_W-2:0], bus.miso};
            end else if (bit_cnt != '0) begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt - BIT_W'(1);
              if (state == SEND_CMD) begin
                mosi   <= cmd_sh[CMD_W-1];
                cmd_sh <= {cmd_sh[CMD_W-2:0], 1'b0};
              end
            end else if (state == SEND_CMD && len_q != '0) begin
              state   <= GET_DATA;
              sclk    <= 1'b0;
              mosi    <= 1'b0;
              bit_cnt <= BIT_W'({len_q, 3'b000}) - BIT_W'(1);
            end else begin
              state <= DEASSERT_CS;
              sclk  <= CPOL;
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
            end
          end
        end

        DEASSERT_CS: begin
          if (half_end) begin
            state   <= IDLE;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          div_cnt <= '0;
          cs_n    <= 1'b1;
          sclk    <= CPOL;
          mosi    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: lane 0 is mode 0 with CLK_DIV=2, lane 1 is mode 3 with CLK_DIV=1.
// Each lane has a response-driving slave model and a monitor that pops expectations on every done.
module tb_spi_cmd_master;
  typedef struct {
    int          lane;
    logic [31:0] rx;
    int          cyc;
    int          rises;
    logic [7:0]  cmd;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  logic        start_a[2] = '{1'b0, 1'b0};
  logic [7:0]  cmd_a[2]   = '{8'h00, 8'h00};
  logic [2:0]  len_a[2]   = '{3'd0, 3'd0};
  logic [31:0] resp_a[2]  = '{32'h0, 32'h0};
  int          done_cnt[2] = '{0, 0};
  int          acc_gap[2]  = '{0, 0};
  int          last_hi[2]  = '{0, 0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int   CD = (g == 0) ? 2 : 1;
    localparam logic CP = (g == 0) ? 1'b0 : 1'b1;

    spi_cmd_master_if #(.CMD_W(8), .MAX_RX_BYTES(4)) bus ();
    spi_cmd_master #(.CLK_DIV(CD), .CMD_W(8), .MAX_RX_BYTES(4), .CPOL(CP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    int          rise_tot  = 0;
    int          rise_base = 0;
    int          rises;
    int          cyc       = 0;
    int          t_acc     = 0;
    int          t_done    = 0;
    int          hi_run    = 0;
    logic [7:0]  mosi_cap  = 8'h00;
    logic        busy_q    = 1'b0;
    logic        rx_moved  = 1'b0;
    logic [31:0] rx_hold   = 32'h0;
    exp_t        e;

    assign rises      = rise_tot - rise_base;
    assign bus.start  = start_a[g];
    assign bus.cmd    = cmd_a[g];
    assign bus.rx_len = len_a[g];
    // Slave presents response bit k after the (8+k)-th rising edge count of the window.
    assign bus.miso   = (rises >= 8 && rises < 40) ? resp_a[g][5'(39 - rises)] : 1'b0;

    always @(negedge bus.cs_n) rise_base = rise_tot;

    always @(posedge bus.sclk) begin
      if (bus.cs_n === 1'b0) begin
        if (rise_tot - rise_base < 8) mosi_cap = {mosi_cap[6:0], bus.mosi};
        rise_tot++;
      end
    end

    always @(negedge clk) begin
      cyc++;
      if (bus.busy && !busy_q) begin
        t_acc      = cyc;
        acc_gap[g] = cyc - t_done;
        rx_hold    = bus.rx_data;
        rx_moved   = 1'b0;
      end
      if (bus.busy && bus.rx_data !== rx_hold) rx_moved = 1'b1;
      if (bus.cs_n) hi_run++;
      else begin
        if (hi_run > 0) last_hi[g] = hi_run;
        hi_run = 0;
      end
      if (bus.done) begin
        done_cnt[g]++;
        t_done = cyc;
        chk("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("lane", g, e.lane);
          chk("rx_data", bus.rx_data, e.rx);
          chk("busy_cycles", cyc - t_acc, e.cyc);
          chk("sclk_rises", rises, e.rises);
          chk("mosi_cmd", mosi_cap, e.cmd);
          chk("end_pins", {bus.cs_n, bus.sclk}, {1'b1, CP});
          chk("rx_stable", rx_moved, 0);
        end
      end
      busy_q = bus.busy;
    end
  end

  task automatic wait_done(int g, int target, int limit);
    int k = 0;
    while (done_cnt[g] < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_count", done_cnt[g], target);
  endtask

  task automatic txn(int g, logic [7:0] c, logic [2:0] l, logic [31:0] r,
                     logic [31:0] x, int cy, int ri);
    int n = done_cnt[g];
    exp_q.push_back('{lane: g, rx: x, cyc: cy, rises: ri, cmd: c});
    cmd_a[g]   = c;
    len_a[g]   = l;
    resp_a[g]  = r;
    start_a[g] = 1'b1;
    @(negedge clk);
    start_a[g] = 1'b0;
    cmd_a[g]   = ~c;
    len_a[g]   = (l == 3'd0) ? 3'd2 : 3'd0;
    wait_done(g, n + 1, 400);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    repeat (3) @(negedge clk);
    chk("rst0_pins", {lane[0].bus.cs_n, lane[0].bus.sclk, lane[0].bus.mosi,
                      lane[0].bus.busy, lane[0].bus.done}, 5'b10000);
    chk("rst0_rx", lane[0].bus.rx_data, 32'h0);
    chk("rst1_pins", {lane[1].bus.cs_n, lane[1].bus.sclk, lane[1].bus.mosi,
                      lane[1].bus.busy, lane[1].bus.done}, 5'b11000);
    chk("rst1_rx", lane[1].bus.rx_data, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // RDID-style read, then zero-length, clamped, and single-byte reads.
    txn(0, 8'h9F, 3'd3, 32'hEF401800, 32'h00EF4018, 132, 32);
    txn(0, 8'h06, 3'd0, 32'hFFFFFFFF, 32'h00000000, 36, 8);
    txn(0, 8'h9F, 3'd7, 32'hDEADBEEF, 32'hDEADBEEF, 164, 40);
    txn(0, 8'hAB, 3'd1, 32'h5A000000, 32'h0000005A, 68, 16);

    // start toggling during a transaction yields exactly one transaction.
    n = done_cnt[0];
    exp_q.push_back('{lane: 0, rx: 32'h0000003C, cyc: 68, rises: 16, cmd: 8'h05});
    cmd_a[0] = 8'h05; len_a[0] = 3'd1; resp_a[0] = 32'h3C000000;
    for (int k = 0; k < 300; k++) begin
      start_a[0] = (k % 2 == 0);
      @(negedge clk);
      if (lane[0].bus.done) break;
    end
    start_a[0] = 1'b0;
    wait_done(0, n + 1, 20);
    repeat (10) @(negedge clk);
    chk("single_done", done_cnt[0], n + 1);

    // start held high: two back-to-back transactions.
    n = done_cnt[0];
    seen = 0;
    exp_q.push_back('{lane: 0, rx: 32'h0000A1B2, cyc: 100, rises: 24, cmd: 8'h9F});
    exp_q.push_back('{lane: 0, rx: 32'h0000A1B2, cyc: 100, rises: 24, cmd: 8'h9F});
    cmd_a[0] = 8'h9F; len_a[0] = 3'd2; resp_a[0] = 32'hA1B20000;
    start_a[0] = 1'b1;
    for (int k = 0; k < 600 && seen < 2; k++) begin
      @(negedge clk);
      if (lane[0].bus.done) seen++;
    end
    start_a[0] = 1'b0;
    wait_done(0, n + 2, 20);
    chk("restart_gap", acc_gap[0], 2);
    chk("cs_high_ge_div", 32'(last_hi[0] >= 2), 1);

    // Reset in the middle of the data phase.
    n = done_cnt[0];
    cmd_a[0] = 8'h9F; len_a[0] = 3'd3; resp_a[0] = 32'h11223300;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    for (int k = 0; k < 300 && lane[0].rises < 12; k++) @(negedge clk);
    chk("reached_data_phase", 32'(lane[0].rises >= 12), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_pins", {lane[0].bus.cs_n, lane[0].bus.sclk, lane[0].bus.busy}, 3'b100);
    chk("rst_mid_rx", lane[0].bus.rx_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", done_cnt[0], n);
    txn(0, 8'h9F, 3'd3, 32'h12345600, 32'h00123456, 132, 32);

    // Mode 3, CLK_DIV=1.
    chk("mode3_idle_sclk", lane[1].bus.sclk, 1'b1);
    txn(1, 8'h9F, 3'd3, 32'hEF401800, 32'h00EF4018, 66, 32);
    txn(1, 8'h06, 3'd0, 32'hFFFFFFFF, 32'h00000000, 18, 8);
    chk("mode3_after_sclk", lane[1].bus.sclk, 1'b1);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
